// File: rtl/bch_15_7_pkg.sv
// Shared definitions for the BCH(15,7) t=2 encoder and the downstream syndrome/decoder block.
// Contents: code dimensions, generator polynomial, encoder FSM state type and the
// single-step LFSR division helper.
package bch_15_7_pkg;

  localparam int unsigned N  = 15;
  localparam int unsigned K  = 7;
  localparam int unsigned NK = 8;

  // g(x) = x^8 + x^7 + x^6 + x^4 + 1; bit 8 is implicit in the shift register.
  localparam logic [8:0] GEN_POLY = 9'h1D1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } enc_state_t;

  // One clock of serial division of d(x)*x^8 by g(x): the data bit enters at the
  // top of the register, so the remainder needs no extra x^8 flush cycles.
  function automatic logic [NK-1:0] lfsr_step(input logic [NK-1:0] rem,
                                                input logic          din,
                                                input logic [NK-1:0] taps);
    logic fb;
    fb = din ^ rem[NK-1];
    return {rem[NK-2:0], 1'b0} ^ ({NK{fb}} & taps);
  endfunction

endpackage

// File: rtl/bch_lfsr_div.sv
// Serial polynomial divider: remainder of (bit stream * x^8) modulo GenPoly.
// Ports:
//   i_Clk   clock, rising edge
//   i_Rst   synchronous active-high reset, clears the remainder
//   i_Clear synchronous clear, starts a new division
//   i_Shift advance the division by one input bit
//   i_Bit   input bit, most significant coefficient first
//   o_Rem   current remainder
module bch_lfsr_div
  import bch_15_7_pkg::*;
#(
  parameter logic [8:0] GenPoly = GEN_POLY
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Clear,
  input  logic          i_Shift,
  input  logic          i_Bit,
  output logic [NK-1:0] o_Rem
);

  logic [NK-1:0] rem_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      rem_q <= '0;
    end else if (i_Shift) begin
      rem_q <= lfsr_step(rem_q, i_Bit, GenPoly[NK-1:0]);
    end
  end

  assign o_Rem = rem_q;

endmodule

// File: rtl/bch_15_7_serial_encoder.sv
// Systematic BCH(15,7) t=2 encoder, one data bit per clock.
// Ports:
//   i_Clk       clock, rising edge
//   i_Rst       synchronous active-high reset
//   i_Valid     upstream data word valid
//   i_DataWord  7-bit data word, bit 6 encoded first
//   o_Ready     encoder accepts a word this cycle (IDLE and not in reset)
//   o_CodeWord  registered {data, parity}, stable while o_Valid is high
//   o_Valid     codeword valid
//   i_Ready     downstream accepts the codeword
module bch_15_7_serial_encoder
  import bch_15_7_pkg::*;
(
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Valid,
  input  logic [K-1:0] i_DataWord,
  output logic         o_Ready,
  output logic [N-1:0] o_CodeWord,
  output logic         o_Valid,
  input  logic         i_Ready
);

  enc_state_t    state_q;
  logic [2:0]    count_q;
  logic [K-1:0]  data_q;
  logic [NK-1:0] rem;
  logic [NK-1:0] rem_next;
  logic [2:0]    bit_idx;
  logic          dbit;
  logic          accept;
  logic          shifting;

  assign o_Ready  = (state_q == IDLE) && !i_Rst;
  assign accept   = o_Ready && i_Valid;
  assign shifting = (state_q == SHIFT);
  assign bit_idx  = 3'd6 - count_q;
  assign dbit     = data_q[bit_idx];
  // Remainder after this edge's shift, captured into the codeword on the last shift.
  assign rem_next = lfsr_step(rem, dbit, GEN_POLY[NK-1:0]);

  bch_lfsr_div #(
    .GenPoly (GEN_POLY)
  ) u_lfsr_div (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Clear (accept),
    .i_Shift (shifting),
    .i_Bit   (dbit),
    .o_Rem   (rem)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      data_q     <= '0;
      o_CodeWord <= '0;
      o_Valid    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_Valid) begin
            data_q  <= i_DataWord;
            count_q <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (count_q == 3'd6) begin
            o_CodeWord <= {data_q, rem_next};
            o_Valid    <= 1'b1;
            state_q    <= DONE;
          end else begin
            count_q <= count_q + 3'd1;
          end
        end
        DONE: begin
          if (i_Ready) begin
            o_Valid <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_15_7_serial_encoder.sv
// Self-checking bench for bch_15_7_serial_encoder: directed vectors, reset abort,
// backpressure, all 128 words in random order against a long-division model, and
// back-to-back streaming.
module tb_bch_15_7_serial_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [6:0]  data_word;
  logic        out_ready;
  logic [14:0] code_word;
  logic        out_valid;
  logic        down_ready;

  int checks   = 0;
  int failures = 0;

  bch_15_7_serial_encoder dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Valid    (in_valid),
    .i_DataWord (data_word),
    .o_Ready    (out_ready),
    .o_CodeWord (code_word),
    .o_Valid    (out_valid),
    .i_Ready    (down_ready)
  );

  always #5 clk = ~clk;

  // Remainder of a 15-bit polynomial modulo g(x) by schoolbook long division.
  function automatic logic [7:0] poly_mod(input logic [14:0] p);
    logic [14:0] v;
    logic [14:0] g;
    v = p;
    g = 15'h01D1;
    for (int i = 14; i >= 8; i--) begin
      if (v[i]) v = v ^ (g << (i - 8));
    end
    return v[7:0];
  endfunction

  function automatic logic [14:0] golden(input logic [6:0] d);
    return {d, poly_mod({d, 8'h00})};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for o_Ready, then presents d for exactly one accept edge.
  task automatic start_word(input logic [6:0] d);
    int n;
    n = 0;
    while (!out_ready && n < 30) begin
      step();
      n++;
    end
    check("ready_timeout", out_ready, 1);
    in_valid  = 1'b1;
    data_word = d;
    step();
    in_valid  = 1'b0;
  endtask

  // Counts edges after the accept edge until o_Valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    check("valid_timeout", out_valid, 1);
  endtask

  task automatic handshake();
    down_ready = 1'b1;
    step();
    down_ready = 1'b0;
  endtask

  task automatic encode(input logic [6:0] d, input int delay, output logic [14:0] cw);
    int lat;
    start_word(d);
    wait_valid(lat);
    cw = code_word;
    for (int i = 0; i < delay; i++) step();
    handshake();
  endtask

  logic [14:0] cw;
  logic [14:0] held;
  logic [14:0] cw_mem [128];
  int          perm   [128];
  int          lat;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    data_word  = '0;
    down_ready = 1'b0;
    step();
    step();
    check("rst_ready", out_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_codeword", code_word, 0);
    rst = 1'b0;
    #1;
    check("idle_ready", out_ready, 1);

    // Word 01 with latency: o_Valid first seen after the 7th edge past accept.
    start_word(7'h01);
    wait_valid(lat);
    check("latency", lat, 7);
    check("cw_01", code_word, 15'h01D1);
    handshake();

    encode(7'h00, 0, cw);
    check("cw_00", cw, 15'h0000);
    encode(7'h7F, 1, cw);
    check("cw_7f", cw, 15'h7FFF);
    encode(7'h03, 0, cw);
    check("cw_03", cw, 15'h03A2);

    // Backpressure: hold DONE for 20 cycles while a new word is offered.
    start_word(7'h2A);
    wait_valid(lat);
    held      = code_word;
    check("bp_first", held, golden(7'h2A));
    in_valid  = 1'b1;
    data_word = 7'h11;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_codeword", code_word, held);
      check("bp_ready", out_ready, 0);
    end
    in_valid = 1'b0;
    handshake();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", out_ready, 1);

    // Reset during the third shift of 7'h55 aborts the word.
    start_word(7'h55);
    step();
    step();
    rst = 1'b1;
    step();
    check("abort_valid", out_valid, 0);
    check("abort_codeword", code_word, 0);
    rst = 1'b0;
    #1;
    check("abort_idle", out_ready, 1);
    for (int i = 0; i < 10; i++) step();
    check("abort_no_output", out_valid, 0);
    encode(7'h01, 0, cw);
    check("post_abort_01", cw, 15'h01D1);

    // All 128 words in random order, random downstream delay.
    for (int i = 0; i < 128; i++) perm[i] = i;
    for (int i = 127; i > 0; i--) begin
      int j;
      int t;
      j       = int'($urandom_range(0, i));
      t       = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 128; i++) begin
      logic [6:0] d;
      d = 7'(perm[i]);
      encode(d, int'($urandom_range(0, 3)), cw);
      cw_mem[perm[i]] = cw;
      check("all_golden", cw, golden(d));
      check("all_syndrome", poly_mod(cw), 0);
    end
    for (int i = 0; i < 24; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 127));
      b = int'($urandom_range(0, 127));
      check("linearity", cw_mem[a ^ b], cw_mem[a] ^ cw_mem[b]);
    end

    // Back-to-back: i_Valid held high, i_Ready held high.
    begin
      logic [6:0]  words [6];
      logic [14:0] exp_q [$];
      int          idx;
      int          n_out;
      int          last_acc;
      for (int i = 0; i < 6; i++) words[i] = 7'($urandom_range(0, 127));
      idx        = 0;
      n_out      = 0;
      last_acc   = -1;
      down_ready = 1'b1;
      in_valid   = 1'b1;
      data_word  = words[0];
      for (int cyc = 0; cyc < 90 && n_out < 6; cyc++) begin
        logic acc;
        logic hs;
        acc = out_ready && in_valid;
        hs  = out_valid && down_ready;
        if (hs) begin
          check("b2b_expected_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("b2b_word", code_word, exp_q.pop_front());
          n_out++;
        end
        step();
        if (acc) begin
          if (last_acc >= 0) check("b2b_period", cyc - last_acc, 9);
          last_acc = cyc;
          exp_q.push_back(golden(words[idx]));
          idx++;
          if (idx == 6) in_valid = 1'b0;
          else data_word = words[idx];
        end
      end
      down_ready = 1'b0;
      check("b2b_accepted", idx, 6);
      check("b2b_delivered", n_out, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
